// File: rtl/psimd_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : psimd_wb_scheduler
// Purpose  : Write-port arbiter (FMA vs FTI) and busy scoreboard for the
//            32x64b PSIMD register file. Optional macro: PSIMD_WB_BYPASS_EN.
// Revision : 1.0  initial release
// ============================================================================
module psimd_wb_scheduler #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rs1,
  input  logic [AW-1:0] iss_rs2,
  input  logic [AW-1:0] iss_rs3,
  input  logic [AW-1:0] iss_rd,
  input  logic          iss_pair,
  output logic          iss_stall,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_rd,
  input  logic          a_pair,
  input  logic [DW-1:0] a_lo,
  input  logic [DW-1:0] a_hi,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_data,
  output logic          wr_enable,
  output logic          reg_fti_ctrl,
  output logic [AW-1:0] rd_address,
  output logic [DW-1:0] dataout_1,
  output logic [DW-1:0] dataout_2,
  output logic          pair_err
);

  localparam logic          c_PTR_A = 1'b0;
  localparam logic [AW-1:0] c_LAST  = AW'(NREG - 1);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_set;
  logic [NREG-1:0] w_busy_clr;
  logic [NREG-1:0] w_busy_chk;
  logic            r_rr_ptr;
  logic            w_grant_a;
  logic            w_grant_b;
  logic            w_a_wrap;
  logic            w_hazard;
  logic            w_issue;
  logic [AW-1:0]   w_iss_rd_p1;
  logic [AW-1:0]   w_a_rd_p1;

  // rd+1 wraps modulo NREG through the AW-bit adder
  assign w_iss_rd_p1 = iss_rd + AW'(1);
  assign w_a_rd_p1   = a_rd + AW'(1);
  assign w_a_wrap    = a_pair && (a_rd == c_LAST);

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (rst_n) begin
      if (a_valid && (!b_valid || (r_rr_ptr == c_PTR_A))) begin
        w_grant_a = 1'b1;
      end else if (b_valid) begin
        w_grant_b = 1'b1;
      end
    end
  end

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;

  always_comb begin
    w_busy_clr = '0;
    if (w_grant_a) begin
      w_busy_clr[a_rd] = 1'b1;
      if (a_pair && !w_a_wrap) begin
        w_busy_clr[w_a_rd_p1] = 1'b1;
      end
    end else if (w_grant_b) begin
      w_busy_clr[b_rd] = 1'b1;
    end
  end

`ifdef PSIMD_WB_BYPASS_EN
  // Registers retiring this cycle are written before any dependent reads them
  assign w_busy_chk = r_busy & ~w_busy_clr;
`else
  assign w_busy_chk = r_busy;
`endif

  assign w_hazard  = w_busy_chk[iss_rs1] | w_busy_chk[iss_rs2] | w_busy_chk[iss_rs3] |
                     w_busy_chk[iss_rd]  | (iss_pair & w_busy_chk[w_iss_rd_p1]);
  assign iss_stall = !rst_n || (iss_valid && w_hazard);
  assign w_issue   = rst_n && iss_valid && !w_hazard;

  always_comb begin
    w_busy_set = '0;
    if (w_issue) begin
      w_busy_set[iss_rd] = 1'b1;
      if (iss_pair && (iss_rd != c_LAST)) begin
        w_busy_set[w_iss_rd_p1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_rr_ptr     <= c_PTR_A;
      pair_err     <= 1'b0;
      wr_enable    <= 1'b0;
      reg_fti_ctrl <= 1'b1;
      rd_address   <= '0;
      dataout_1    <= '0;
      dataout_2    <= '0;
    end else begin
      // set after clear: a same-cycle set of a retiring register wins
      r_busy    <= (r_busy & ~w_busy_clr) | w_busy_set;
      wr_enable <= w_grant_a | w_grant_b;
      if (a_valid && b_valid) begin
        r_rr_ptr <= ~r_rr_ptr;
      end
      if (w_grant_a) begin
        rd_address   <= a_rd;
        reg_fti_ctrl <= ~a_pair | w_a_wrap;
        dataout_1    <= a_lo;
        dataout_2    <= w_a_wrap ? '0 : a_hi;
        if (w_a_wrap) begin
          pair_err <= 1'b1;
        end
      end else if (w_grant_b) begin
        rd_address   <= b_rd;
        reg_fti_ctrl <= 1'b1;
        dataout_1    <= b_data;
        dataout_2    <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psimd_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_psimd_wb_scheduler
// Purpose  : Directed self-checking bench for psimd_wb_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_psimd_wb_scheduler;

  localparam int AW = 5;
  localparam int DW = 64;
`ifdef PSIMD_WB_BYPASS_EN
  localparam logic c_BYP = 1'b1;
`else
  localparam logic c_BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iss_valid, iss_pair, iss_stall;
  logic [AW-1:0] iss_rs1, iss_rs2, iss_rs3, iss_rd;
  logic          a_valid, a_ready, a_pair;
  logic [AW-1:0] a_rd;
  logic [DW-1:0] a_lo, a_hi;
  logic          b_valid, b_ready;
  logic [AW-1:0] b_rd;
  logic [DW-1:0] b_data;
  logic          wr_enable, reg_fti_ctrl, pair_err;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] dataout_1, dataout_2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  psimd_wb_scheduler #(.NREG(32), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rs3(iss_rs3),
    .iss_rd(iss_rd), .iss_pair(iss_pair), .iss_stall(iss_stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_pair(a_pair),
    .a_lo(a_lo), .a_hi(a_hi),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .wr_enable(wr_enable), .reg_fti_ctrl(reg_fti_ctrl), .rd_address(rd_address),
    .dataout_1(dataout_1), .dataout_2(dataout_2), .pair_err(pair_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 ns after the edge, checks happen 2 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rd,
                       input logic pr);
    iss_valid = v; iss_rs1 = rs1; iss_rs2 = rs1; iss_rs3 = rs1; iss_rd = rd; iss_pair = pr;
  endtask

  initial begin
    rst_n = 1'b0;
    issue(1'b1, 5'd0, 5'd0, 1'b0);
    a_valid = 1'b1; a_rd = '0; a_pair = 1'b0; a_lo = '0; a_hi = '0;
    b_valid = 1'b1; b_rd = '0; b_data = '0;

    // reset state
    step(); step(); #2;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_stall", iss_stall, 1);
    check("rst_wr_en", wr_enable, 0);
    check("rst_fti", reg_fti_ctrl, 1);
    check("rst_rd_addr", rd_address, 0);
    check("rst_d1", dataout_1, 0);
    check("rst_d2", dataout_2, 0);
    check("rst_pair_err", pair_err, 0);

    // RAW stall on a pair destination until the FMA returns it
    step();
    rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    issue(1'b1, 5'd0, 5'd4, 1'b1);
    #2 check("t1_issue_free", iss_stall, 0);
    step();
    issue(1'b1, 5'd5, 5'd10, 1'b0);
    #2 check("t1_raw_stall", iss_stall, 1);
    step();
    a_valid = 1'b1; a_rd = 5'd4; a_pair = 1'b1; a_lo = 64'hA0; a_hi = 64'hA1;
    #2 check("t1_a_ready", a_ready, 1);
    check("t1_stall_grant", iss_stall, c_BYP ? 1'b0 : 1'b1);
    step();
    a_valid = 1'b0;
    #2 check("t1_wr_en", wr_enable, 1);
    check("t1_rd_addr", rd_address, 4);
    check("t1_fti", reg_fti_ctrl, 0);
    check("t1_d1", dataout_1, 64'hA0);
    check("t1_d2", dataout_2, 64'hA1);
    check("t1_stall_after", iss_stall, c_BYP ? 1'b1 : 1'b0);
    step();
    issue(1'b0, 5'd0, 5'd0, 1'b0);
    #2 check("t1_wr_idle", wr_enable, 0);
    check("t1_rd_hold", rd_address, 4);
    check("t1_d1_hold", dataout_1, 64'hA0);
    // retire r10 so later tests start clean
    a_valid = 1'b1; a_rd = 5'd10; a_pair = 1'b0; a_lo = 64'h5;
    step();
    a_valid = 1'b0;
    step();

    // contested round robin: A,B,A,B
    a_valid = 1'b1; a_rd = 5'd1; a_pair = 1'b0; a_lo = 64'h100; a_hi = 64'h0;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 64'h200;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("t2_a_ready", a_ready, (i % 2) == 0);
      check("t2_b_ready", b_ready, (i % 2) == 1);
      if (i > 0) begin
        check("t2_wr_en", wr_enable, 1);
        check("t2_rd_addr", rd_address, ((i - 1) % 2 == 0) ? 1 : 2);
      end
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #2 check("t2_wr_en_last", wr_enable, 1);
    check("t2_rd_last", rd_address, 2);
    check("t2_d1_last", dataout_1, 64'h200);
    step();
    #2 check("t2_wr_idle", wr_enable, 0);

    // pair write at the top register wraps to a single write
    a_valid = 1'b1; a_rd = 5'd31; a_pair = 1'b1; a_lo = 64'h11; a_hi = 64'h22;
    #2 check("t3_err_before", pair_err, 0);
    step();
    a_valid = 1'b0;
    #2 check("t3_wr_en", wr_enable, 1);
    check("t3_fti", reg_fti_ctrl, 1);
    check("t3_rd_addr", rd_address, 31);
    check("t3_d1", dataout_1, 64'h11);
    check("t3_pair_err", pair_err, 1);
    step();
    #2 check("t3_err_sticky", pair_err, 1);

    // FTI single write
    b_valid = 1'b1; b_rd = 5'd7; b_data = 64'hDEAD;
    #2 check("t4_b_ready", b_ready, 1);
    step();
    b_valid = 1'b0;
    #2 check("t4_wr_en", wr_enable, 1);
    check("t4_rd_addr", rd_address, 7);
    check("t4_d1", dataout_1, 64'hDEAD);
    check("t4_d2", dataout_2, 0);
    check("t4_fti", reg_fti_ctrl, 1);

    // dependent issue in the grant cycle of r9
    issue(1'b1, 5'd0, 5'd9, 1'b0);
    #2 check("t5_issue_r9", iss_stall, 0);
    step();
    issue(1'b1, 5'd9, 5'd12, 1'b0);
    a_valid = 1'b1; a_rd = 5'd9; a_pair = 1'b0; a_lo = 64'h99;
    #2 check("t5_a_ready", a_ready, 1);
    check("t5_stall_grant", iss_stall, c_BYP ? 1'b0 : 1'b1);
    step();
    a_valid = 1'b0;
    #2 check("t5_stall_after", iss_stall, c_BYP ? 1'b1 : 1'b0);
    step();
    issue(1'b0, 5'd0, 5'd0, 1'b0);

    // fill r0..r7, then reset with A waiting
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 5'd20, 5'(2 * k), 1'b1);
      #2 check("t6_fill", iss_stall, 0);
      step();
    end
    issue(1'b1, 5'd3, 5'd20, 1'b0);
    #2 check("t6_busy_set", iss_stall, 1);
    rst_n = 1'b0;
    a_valid = 1'b1; a_rd = 5'd0; a_pair = 1'b0; a_lo = 64'h77;
    #1 check("t6_a_ready_rst", a_ready, 0);
    step();
    #2 check("t6_wr_en", wr_enable, 0);
    check("t6_pair_err", pair_err, 0);
    check("t6_a_ready", a_ready, 0);
    check("t6_b_ready", b_ready, 0);
    rst_n = 1'b1; a_valid = 1'b0;
    issue(1'b1, 5'd3, 5'd5, 1'b1);
    #2 check("t6_busy_clear", iss_stall, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
